// File: rtl/jtexterm_palctl.sv
// -----------------------------------------------------------------------------
// jtexterm_palctl
// Palette RAM access controller for the Exterm colour mixer.
//
// Owns the single-port 1024x8 palette RAM. Each pixel period is split into
// four slots counted from pxl_cen:
//   slot0 : video issues the hi-byte address {idx,0}
//   slot1 : video captures hi, issues the lo-byte address {idx,1}
//   slot2 : video captures lo into the pending word      (CPU slot)
//   slot3 : free                                         (CPU slot)
// During blanking every slot belongs to the CPU.
//
// CPU accesses stall on cpu_wait until one read or write has been made. The
// read data port is only used by the video path in slots 1 and 2, so a CPU
// read issued in slot3 can safely capture its data in the following slot0.
//
// With CLRW=1 the controller first writes zero to every RAM address, one per
// clk, before the CPU path is allowed to run.
// -----------------------------------------------------------------------------
module jtexterm_palctl #(
  parameter int CLRW = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [8:0] pxl_idx,
  input  logic       cpu_cs,
  input  logic       cpu_wrn,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  output logic [7:0] cpu_din,
  output logic       cpu_wait,
  output logic [9:0] ram_addr,
  output logic [7:0] ram_din,
  output logic       ram_we,
  input  logic [7:0] ram_dout,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [4:0] blue
);

  // CPU access sequencer. CLEAR only exists when the clear-on-reset option
  // is enabled; it shares the encoding so reset can select either start state.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    RDCAP = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  localparam state_t RST_STATE = (CLRW != 0) ? CLEAR : IDLE;
  localparam logic [9:0] LAST_ADDR = 10'h3ff;

  state_t      state;
  logic [1:0]  slot;
  logic        line_act;   // current pixel period is active video
  logic [8:0]  pix_idx;    // palette entry being fetched this period
  logic [9:0]  clr_addr;
  logic [6:0]  hi_byte;    // bit 7 of the hi byte is unused by the colour
  logic [14:0] pend_word;  // colour for the pixel shown at the next pxl_cen

  logic        cpu_slot;
  logic        vid_hi;
  logic        vid_lo;
  logic        vid_cap;
  logic        cpu_go;

  // Slot ownership. Video owns slots 0 and 1 only during active video.
  assign cpu_slot = !line_act || slot[1];
  assign vid_hi   = line_act && (slot == 2'd0);
  assign vid_lo   = line_act && (slot == 2'd1);
  assign vid_cap  = line_act && (slot == 2'd2);
  assign cpu_go   = (state == ISSUE) && cpu_slot;

  // Slot counter: restarts on every pxl_cen, saturates at slot3.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= 2'd0;
    end else if (pxl_cen) begin
      slot <= 2'd0;
    end else if (slot != 2'd3) begin
      slot <= slot + 2'd1;
    end
  end

  // Video fetch pipeline: sample the pixel at pxl_cen, assemble hi/lo bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_act  <= 1'b0;
      pix_idx   <= 9'd0;
      hi_byte   <= 7'd0;
      pend_word <= 15'd0;
    end else begin
      if (pxl_cen) begin
        line_act <= LHBL & LVBL;
        pix_idx  <= pxl_idx;
      end
      if (vid_lo) begin
        hi_byte <= ram_dout[6:0];
      end
      if (vid_cap) begin
        pend_word <= {hi_byte, ram_dout};
      end
    end
  end

  // Colour outputs: load the fetched word at pxl_cen, black when the
  // previous pixel was blanked or the RAM is still being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      red   <= 5'd0;
      green <= 5'd0;
      blue  <= 5'd0;
    end else if (pxl_cen) begin
      if (line_act && (state != CLEAR)) begin
        {red, green, blue} <= pend_word;
      end else begin
        {red, green, blue} <= 15'd0;
      end
    end
  end

  // CPU access FSM and clear sequencer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RST_STATE;
      clr_addr <= 10'd0;
      cpu_din  <= 8'd0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 10'd1;
          if (clr_addr == LAST_ADDR) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (cpu_cs) begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (cpu_slot) begin
            state <= cpu_wrn ? RDCAP : DONE;
          end
        end
        RDCAP: begin
          // The RAM output this cycle belongs to the address issued by the
          // CPU in the previous cycle, even if video owns the address port.
          cpu_din <= ram_dout;
          state   <= DONE;
        end
        DONE: begin
          if (!cpu_cs) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port mux: clear, then video (slots 0/1), then the CPU in its slots.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    ram_addr = 10'd0;
    ram_din  = 8'd0;
    ram_we   = 1'b0;
    if (state == CLEAR) begin
      ram_addr = clr_addr;
      ram_we   = 1'b1;
    end else if (vid_hi) begin
      ram_addr = {pix_idx, 1'b0};
    end else if (vid_lo) begin
      ram_addr = {pix_idx, 1'b1};
    end else if (cpu_go) begin
      ram_addr = cpu_addr;
      if (!cpu_wrn) begin
        ram_din = cpu_dout;
        // A write pending when reset hits is abandoned, not committed.
        ram_we  = !rst;
      end
    end
  end

  // CPU stall: follows cs while idle or clearing, held until the access ends.
  always_comb begin
    cpu_wait = 1'b0;
    case (state)
      IDLE, CLEAR:  cpu_wait = cpu_cs;
      ISSUE, RDCAP: cpu_wait = 1'b1;
      DONE:         cpu_wait = 1'b0;
      default:      cpu_wait = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_jtexterm_palctl.sv
// -----------------------------------------------------------------------------
// tb_jtexterm_palctl
// Directed bench for the palette controller with a behavioural 1024x8 RAM.
// Inputs are driven 2 ns after each rising edge; phase tracks the pixel
// cadence (phase 0 = pxl_cen cycle, phase 1..3 = slots 0..2, phase 0 = slot3).
// -----------------------------------------------------------------------------
module tb_jtexterm_palctl;

  logic       clk;
  logic       rst;
  logic       pxl_cen;
  logic       LHBL;
  logic       LVBL;
  logic [8:0] pxl_idx;
  logic       cpu_cs;
  logic       cpu_wrn;
  logic [9:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic [7:0] cpu_din;
  logic       cpu_wait;
  logic [9:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic [4:0] red;
  logic [4:0] green;
  logic [4:0] blue;

  jtexterm_palctl #(.CLRW(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .pxl_idx  (pxl_idx),
    .cpu_cs   (cpu_cs),
    .cpu_wrn  (cpu_wrn),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_din  (cpu_din),
    .cpu_wait (cpu_wait),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  int errors = 0;
  int checks = 0;

  // bench state
  int phase = 0;
  bit pxl_run = 0;
  bit clr_mon = 0;
  bit vid_mon = 0;
  int clr_exp = 0;
  int clr_bad = 0;
  int we_cnt = 0;
  int bad_we = 0;
  int last_we_phase = -1;

  logic [7:0] mem [1024];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Palette RAM model: synchronous write, 1-clk registered read
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  // Write-strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (clr_mon) begin
      if (ram_we) begin
        we_cnt = we_cnt + 1;
        if (ram_addr !== clr_exp[9:0] || ram_din !== 8'd0) clr_bad = clr_bad + 1;
        clr_exp = clr_exp + 1;
      end
    end else if (ram_we) begin
      we_cnt = we_cnt + 1;
      last_we_phase = phase;
      if (vid_mon && (phase == 1 || phase == 2)) bad_we = bad_we + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    if (pxl_run) begin
      phase = (phase + 1) & 3;
      pxl_cen = (phase == 0);
    end else begin
      pxl_cen = 1'b0;
    end
  endtask

  // Advance until just after the next pxl_cen edge (slot0 cycle)
  task automatic go_slot0();
    cyc();
    for (int i = 0; i < 8 && phase != 1; i++) cyc();
  endtask

  task automatic check_rgb(input string tag, input logic [4:0] r, input logic [4:0] g,
                           input logic [4:0] b);
    check({tag, "_rgb"}, {red, green, blue}, {r, g, b});
  endtask

  // One CPU access; lat = edges until cpu_wait dropped
  task automatic cpu_access(input logic wrn, input logic [9:0] a, input logic [7:0] d,
                            output logic [7:0] rd, output int lat);
    cpu_wrn  = wrn;
    cpu_addr = a;
    cpu_dout = d;
    cpu_cs   = 1'b1;
    lat = 0;
    #1;
    while (cpu_wait && lat < 20) begin
      cyc();
      lat++;
    end
    rd = cpu_din;
    cpu_cs = 1'b0;
    cyc();
  endtask

  function automatic int count_nonzero(input int skip);
    int n = 0;
    for (int i = 0; i < 1024; i++) if (i != skip && mem[i] !== 8'd0) n++;
    return n;
  endfunction

  initial begin
    logic [7:0] rd;
    int lat;

    for (int i = 0; i < 1024; i++) mem[i] = 8'hEE;
    rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b1; LVBL = 1'b1; pxl_idx = 9'd0;
    cpu_cs = 1'b0; cpu_wrn = 1'b1; cpu_addr = 10'd0; cpu_dout = 8'd0;

    // ---- reset state and clear sequence ----
    cyc();
    cyc();
    rst = 1'b0;
    clr_mon = 1'b1; clr_exp = 0; clr_bad = 0; we_cnt = 0;
    #1;
    check("rst_we", ram_we, 1'b1);
    check("rst_addr", ram_addr, 10'd0);
    check("rst_din", ram_din, 8'd0);
    check("rst_cpu_din", cpu_din, 8'd0);
    check_rgb("rst", 5'd0, 5'd0, 5'd0);
    check("rst_wait_lo", cpu_wait, 1'b0);
    cpu_cs = 1'b1;
    #1;
    check("clear_wait_follows_cs", cpu_wait, 1'b1);
    cpu_cs = 1'b0;
    repeat (1024) cyc();
    clr_mon = 1'b0;
    check("clear_we_count", we_cnt, 1024);
    check("clear_seq_errors", clr_bad, 0);
    check("clear_end_we", ram_we, 1'b0);
    check("clear_ram_zero", count_nonzero(-1), 0);

    // ---- blanking-time CPU accesses (no pxl_cen yet, so all CPU slots) ----
    cpu_access(1'b0, 10'h00A, 8'h7C, rd, lat);
    check("blank_wr_lat", lat, 2);
    check("blank_wr_mem", mem[10'h00A], 8'h7C);
    cpu_access(1'b0, 10'h00B, 8'h1F, rd, lat);
    cpu_access(1'b0, 10'h00C, 8'h03, rd, lat);
    cpu_access(1'b0, 10'h00D, 8'hE0, rd, lat);
    cpu_access(1'b0, 10'h000, 8'h12, rd, lat);
    cpu_access(1'b0, 10'h001, 8'h34, rd, lat);
    cpu_access(1'b0, 10'h3FF, 8'hA5, rd, lat);
    cpu_access(1'b1, 10'h00B, 8'h00, rd, lat);
    check("blank_rd_lat", lat, 3);
    check("blank_rd_data", rd, 8'h1F);

    // ---- palette decode in active video ----
    pxl_run = 1'b1; phase = 3; pxl_idx = 9'd5;
    go_slot0();                      // edge samples entry 5
    check_rgb("first_pixel_black", 5'd0, 5'd0, 5'd0);
    pxl_idx = 9'd6;
    go_slot0();                      // shows entry 5, samples entry 6
    check_rgb("entry5", 5'd31, 5'd0, 5'd31);
    go_slot0();                      // shows entry 6
    check_rgb("entry6", 5'd0, 5'd31, 5'd0);

    // ---- arbitration: CPU request at slot0 in continuous active video ----
    vid_mon = 1'b1; bad_we = 0;
    cpu_access(1'b1, 10'h00B, 8'h00, rd, lat);
    check("act_rd_data", rd, 8'h1F);
    check("act_rd_lat", lat, 4);
    go_slot0();
    check_rgb("act_rd_pixel", 5'd0, 5'd31, 5'd0);
    cpu_access(1'b0, 10'h100, 8'h5A, rd, lat);
    check("act_wr_lat", lat, 3);
    check("act_wr_slot2", last_we_phase, 3);
    check("act_wr_mem", mem[10'h100], 8'h5A);
    check("act_no_we_in_video_slots", bad_we, 0);
    vid_mon = 1'b0;

    // ---- CPU read issued in slot3, completing in the next slot0 ----
    pxl_idx = 9'd0;
    go_slot0();                      // samples entry 0
    pxl_idx = 9'd5;
    cyc();
    cyc();                           // slot2: request -> issue in slot3
    cpu_access(1'b1, 10'h3FF, 8'h00, rd, lat);
    check("slot3_rd_data", rd, 8'hA5);
    check("slot3_rd_lat", lat, 3);
    check_rgb("slot3_entry0", 5'd4, 5'd17, 5'd20);
    go_slot0();
    check_rgb("slot3_next_entry5", 5'd31, 5'd0, 5'd31);

    // ---- horizontal blanking ----
    LHBL = 1'b0;
    go_slot0();                      // shows the last active pixel
    check_rgb("blank_prev_active", 5'd31, 5'd0, 5'd31);
    go_slot0();
    check_rgb("blank_black", 5'd0, 5'd0, 5'd0);
    cpu_access(1'b0, 10'h200, 8'h66, rd, lat);
    check("hblank_wr_lat", lat, 2);
    check("hblank_wr_mem", mem[10'h200], 8'h66);

    // ---- handshake: one access per cs assertion ----
    we_cnt = 0;
    cpu_wrn = 1'b0; cpu_addr = 10'h201; cpu_dout = 8'h11; cpu_cs = 1'b1;
    lat = 0;
    #1;
    while (cpu_wait && lat < 20) begin cyc(); lat++; end
    repeat (10) cyc();
    check("hold_cs_wait_lo", cpu_wait, 1'b0);
    check("hold_cs_one_write", we_cnt, 1);
    cpu_cs = 1'b0;
    cyc();
    cpu_access(1'b0, 10'h201, 8'h22, rd, lat);
    check("second_access_writes", we_cnt, 2);
    check("second_access_mem", mem[10'h201], 8'h22);

    // ---- reset during a pending write in active video ----
    LHBL = 1'b1;
    go_slot0();                      // line becomes active
    cpu_wrn = 1'b0; cpu_addr = 10'h300; cpu_dout = 8'h99; cpu_cs = 1'b1;
    cyc();                           // slot1: waiting
    cyc();                           // slot2: write would issue here
    rst = 1'b1;
    #1;
    check("rst_blocks_write", ram_we, 1'b0);
    cyc();
    rst = 1'b0;
    clr_mon = 1'b1; clr_exp = 0; clr_bad = 0; we_cnt = 0;
    #1;
    check("rst2_wait_follows_cs", cpu_wait, 1'b1);
    check("rst2_clear_we", ram_we, 1'b1);
    check("rst2_clear_addr", ram_addr, 10'd0);
    check("rst2_cpu_din", cpu_din, 8'd0);
    repeat (1024) cyc();
    clr_mon = 1'b0;
    check("rst2_clear_we_count", we_cnt, 1024);
    check("rst2_clear_seq_errors", clr_bad, 0);
    check("rst2_clear_end_we", ram_we, 1'b0);
    lat = 0;
    while (cpu_wait && lat < 20) begin cyc(); lat++; end
    check("post_clear_wait_lo", cpu_wait, 1'b0);
    check("post_clear_write", mem[10'h300], 8'h99);
    check("rst2_ram_zero", count_nonzero(10'h300), 0);
    cpu_cs = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
